// File: rtl/operand_loader.sv
// Two-operand entry front end for the shiftleft stage: one debounced load
// button steps WAIT_A -> WAIT_B -> READY, capturing the switches into a then b.
module operand_loader #(
    parameter int N        = 8,
    parameter int DEBOUNCE = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] sw,
    input  logic         btn,
    input  logic         clear,
    output logic [N-1:0] a,
    output logic [N-1:0] b,
    output logic         valid,
    output logic [1:0]   state
);

    localparam int CW = $clog2(DEBOUNCE + 1);

    localparam logic [1:0] S_WAIT_A = 2'd0;
    localparam logic [1:0] S_WAIT_B = 2'd1;
    localparam logic [1:0] S_READY  = 2'd2;

    localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE);
    localparam logic [CW-1:0] CNT_FIRE = CW'(DEBOUNCE - 1);

    logic [CW-1:0] cnt;
    logic          press;
    logic          wipe;

    assign wipe = rst || clear;

    // The count saturates one past the fire value, so a held button fires once.
    assign press = btn && (cnt == CNT_FIRE);

    always_ff @(posedge clk) begin
        if (wipe) begin
            cnt <= '0;
        end else if (!btn) begin
            cnt <= '0;
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wipe) begin
            state <= S_WAIT_A;
            a     <= '0;
            b     <= '0;
        end else begin
            case (state)
                S_WAIT_A: begin
                    if (press) begin
                        a     <= sw;
                        state <= S_WAIT_B;
                    end
                end
                S_WAIT_B: begin
                    if (press) begin
                        b     <= sw;
                        state <= S_READY;
                    end
                end
                S_READY: begin
                    // b is kept until the next WAIT_B press replaces it.
                    if (press) begin
                        a     <= sw;
                        state <= S_WAIT_B;
                    end
                end
                default: begin
                    state <= S_WAIT_A;
                end
            endcase
        end
    end

    assign valid = (state == S_READY);

endmodule
